// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer: sequences CE/OE/WE for one SRAM read or write per request
// with programmable setup, access and hold cycles; all pin outputs are registered.
module sram_access_sequencer #(
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_BANKS     = 2,
    parameter int SETUP_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_req,
    input  logic                  i_RW,
    input  logic [2:0]            i_bank,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_busy,
    output logic                  o_ack,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_dq,
    output logic                  o_sram_dq_oe,
    input  logic [DATA_WIDTH-1:0] i_sram_dq,
    output logic [NUM_BANKS-1:0]  o_CE,
    output logic [NUM_BANKS-1:0]  o_CE2,
    output logic                  o_RE,
    output logic                  o_WE
);
    localparam int MAXC = (SETUP_CYCLES > ACCESS_CYCLES)
                        ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                        : ((ACCESS_CYCLES > HOLD_CYCLES) ? ACCESS_CYCLES : HOLD_CYCLES);
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] ACCESS_LD = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

    state_t                state, nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  rw_q, n_rw, take, n_valid, cap;
    logic [2:0]            bank_q, n_bank;
    logic [NUM_BANKS-1:0]  sel;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        take    = 1'b0;
        case (state)
            IDLE: if (i_req) begin
                take    = 1'b1;
                nxt     = (SETUP_CYCLES > 0) ? SETUP : ACCESS;
                cnt_nxt = (SETUP_CYCLES > 0) ? SETUP_LD : ACCESS_LD;
            end
            SETUP: if (cnt == '0) begin
                nxt     = ACCESS;
                cnt_nxt = ACCESS_LD;
            end else cnt_nxt = cnt - CW'(1);
            ACCESS: if (cnt == '0) begin
                nxt     = (HOLD_CYCLES > 0) ? HOLD : DONE;
                cnt_nxt = HOLD_LD;
            end else cnt_nxt = cnt - CW'(1);
            HOLD: if (cnt == '0) nxt = DONE;
                  else cnt_nxt = cnt - CW'(1);
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // Outputs are decoded from the post-edge request, so acceptance uses the live inputs
        n_rw    = take ? i_RW : rw_q;
        n_bank  = take ? i_bank : bank_q;
        n_valid = int'(n_bank) < NUM_BANKS;
        for (int b = 0; b < NUM_BANKS; b++)
            sel[b] = n_valid && (nxt == SETUP || nxt == ACCESS || nxt == HOLD) && n_bank == 3'(b);
        cap = state == ACCESS && nxt != ACCESS && rw_q && int'(bank_q) < NUM_BANKS;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rw_q         <= 1'b1;
            bank_q       <= '0;
            o_sram_addr  <= '0;
            o_sram_dq    <= '0;
            o_rdata      <= '0;
            o_busy       <= 1'b0;
            o_ack        <= 1'b0;
            o_err        <= 1'b0;
            o_CE         <= '1;
            o_CE2        <= '0;
            o_RE         <= 1'b1;
            o_WE         <= 1'b1;
            o_sram_dq_oe <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_nxt;
            rw_q   <= n_rw;
            bank_q <= n_bank;
            if (take) begin
                o_sram_addr <= i_addr;
                o_sram_dq   <= i_wdata;
            end
            if (cap) o_rdata <= i_sram_dq;
            o_busy       <= nxt != IDLE;
            o_ack        <= nxt == DONE;
            o_err        <= nxt == DONE && !n_valid;
            o_CE         <= ~sel;
            o_CE2        <= sel;
            o_RE         <= !(nxt == ACCESS && n_rw);
            o_WE         <= !(nxt == ACCESS && !n_rw);
            o_sram_dq_oe <= !n_rw && (nxt == ACCESS || nxt == HOLD);
        end
    end
endmodule

// File: tb/tb_sram_access_sequencer.sv
// tb_sram_access_sequencer: two configurations checked every cycle against a
// cycle-offset transaction model, plus literal waveform expectations.
module tb_sram_access_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    typedef struct packed {
        logic busy, ack, err, re, we, oe;
        logic [7:0] ce, ce2;
    } exp_t;
    typedef struct packed {
        int k;
        logic rw;
        logic [2:0] bank;
        logic [16:0] addr;
        logic [7:0] wd, rd;
    } mst_t;

    logic        rst_a = 0, req_a = 0, rw_a = 0;
    logic [2:0]  bank_a = 0;
    logic [16:0] addr_a = 0;
    logic [7:0]  wdata_a = 0, dq_a = 0;
    logic        busy_a, ack_a, err_a, oe_a, re_a, we_a;
    logic [7:0]  rdata_a, sdq_a;
    logic [16:0] saddr_a;
    logic [1:0]  ce_a, ce2_a;

    logic        rst_b = 0, req_b = 0, rw_b = 0;
    logic [2:0]  bank_b = 0;
    logic [16:0] addr_b = 0;
    logic [7:0]  wdata_b = 0, dq_b = 0;
    logic        busy_b, ack_b, err_b, oe_b, re_b, we_b;
    logic [7:0]  rdata_b, sdq_b;
    logic [16:0] saddr_b;
    logic [3:0]  ce_b, ce2_b;

    sram_access_sequencer dut_a (
        .i_clk(clk), .i_reset_n(rst_a), .i_req(req_a), .i_RW(rw_a), .i_bank(bank_a),
        .i_addr(addr_a), .i_wdata(wdata_a), .o_busy(busy_a), .o_ack(ack_a), .o_err(err_a),
        .o_rdata(rdata_a), .o_sram_addr(saddr_a), .o_sram_dq(sdq_a), .o_sram_dq_oe(oe_a),
        .i_sram_dq(dq_a), .o_CE(ce_a), .o_CE2(ce2_a), .o_RE(re_a), .o_WE(we_a)
    );

    sram_access_sequencer #(.NUM_BANKS(4), .SETUP_CYCLES(0), .ACCESS_CYCLES(1), .HOLD_CYCLES(0)) dut_b (
        .i_clk(clk), .i_reset_n(rst_b), .i_req(req_b), .i_RW(rw_b), .i_bank(bank_b),
        .i_addr(addr_b), .i_wdata(wdata_b), .o_busy(busy_b), .o_ack(ack_b), .o_err(err_b),
        .o_rdata(rdata_b), .o_sram_addr(saddr_b), .o_sram_dq(sdq_b), .o_sram_dq_oe(oe_b),
        .i_sram_dq(dq_b), .o_CE(ce_b), .o_CE2(ce2_b), .o_RE(re_b), .o_WE(we_b)
    );

    // k counts cycles since acceptance: 1..s setup, then a access, h hold, and k=s+a+h+1 is the ack cycle
    function automatic mst_t step(mst_t m, int s, int a, int h, int nb, logic rn, logic req,
                                  logic rw, logic [2:0] bank, logic [16:0] addr,
                                  logic [7:0] wd, logic [7:0] dq);
        mst_t n;
        n = m;
        if (!rn) return '0;
        if (m.k == s + a && m.rw && int'(m.bank) < nb) n.rd = dq;
        if (m.k == 0) begin
            if (req) begin
                n.k = 1; n.rw = rw; n.bank = bank; n.addr = addr; n.wd = wd;
            end
        end else n.k = (m.k == s + a + h + 1) ? 0 : m.k + 1;
        return n;
    endfunction

    function automatic exp_t expect_at(mst_t m, int s, int a, int h, int nb);
        exp_t e;
        logic act, acc;
        logic [7:0] mask, sel;
        act   = m.k >= 1 && m.k <= s + a + h;
        acc   = m.k > s && m.k <= s + a;
        mask  = 8'((1 << nb) - 1);
        sel   = (act && int'(m.bank) < nb) ? 8'(1 << m.bank) : 8'h00;
        e.busy = m.k >= 1;
        e.ack  = m.k == s + a + h + 1;
        e.err  = e.ack && int'(m.bank) >= nb;
        e.re   = !(acc && m.rw);
        e.we   = !(acc && !m.rw);
        e.oe   = !m.rw && m.k > s && m.k <= s + a + h;
        e.ce   = ~sel & mask;
        e.ce2  = sel;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic cmp(string t, exp_t e, mst_t m, logic busy, logic ack, logic err, logic re,
                       logic we, logic oe, logic [7:0] ce, logic [7:0] ce2, logic [7:0] rdata,
                       logic [16:0] saddr, logic [7:0] sdq);
        chk({t, "_busy"}, 32'(busy), 32'(e.busy));
        chk({t, "_ack"}, 32'(ack), 32'(e.ack));
        chk({t, "_err"}, 32'(err), 32'(e.err));
        chk({t, "_re"}, 32'(re), 32'(e.re));
        chk({t, "_we"}, 32'(we), 32'(e.we));
        chk({t, "_dq_oe"}, 32'(oe), 32'(e.oe));
        chk({t, "_ce"}, 32'(ce), 32'(e.ce));
        chk({t, "_ce2"}, 32'(ce2), 32'(e.ce2));
        chk({t, "_rdata"}, 32'(rdata), 32'(m.rd));
        chk({t, "_addr"}, 32'(saddr), 32'(m.addr));
        chk({t, "_wdata"}, 32'(sdq), 32'(m.wd));
    endtask

    mst_t ma = '0, mb = '0;

    always @(posedge clk) begin
        ma <= step(ma, 1, 2, 1, 2, rst_a, req_a, rw_a, bank_a, addr_a, wdata_a, dq_a);
        mb <= step(mb, 0, 1, 0, 4, rst_b, req_b, rw_b, bank_b, addr_b, wdata_b, dq_b);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a", expect_at(ma, 1, 2, 1, 2), ma, busy_a, ack_a, err_a, re_a, we_a, oe_a,
                8'(ce_a), 8'(ce2_a), rdata_a, saddr_a, sdq_a);
            cmp("b", expect_at(mb, 0, 1, 0, 4), mb, busy_b, ack_b, err_b, re_b, we_b, oe_b,
                8'(ce_b), 8'(ce2_b), rdata_b, saddr_b, sdq_b);
        end
    end

    logic [15:0] v_we, v_re, v_ce0, v_ce1, v_ceall, v_oe, v_ack, v_err, v_busy, v_c20, v_c21;
    logic [7:0]  r4;

    // Bit k of each vector holds the output seen in cycle k, cycle 0 being the request cycle
    task automatic txn_a(input logic rw, input logic [2:0] bank, input logic [16:0] addr,
                         input logic [7:0] wd, input int n, input bit hold, input int rst_at);
        {v_we, v_re, v_ce0, v_ce1, v_ceall, v_oe, v_ack, v_err, v_busy, v_c20, v_c21} = '0;
        r4 = '0;
        @(negedge clk);
        req_a = 1; rw_a = rw; bank_a = bank; addr_a = addr; wdata_a = wd;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (k > 0) req_a = hold ? !(k == 3 || k == 9) : 1'b0;
            v_we[k] = we_a; v_re[k] = re_a; v_ce0[k] = ce_a[0]; v_ce1[k] = ce_a[1];
            v_ceall[k] = &ce_a; v_oe[k] = oe_a; v_ack[k] = ack_a; v_err[k] = err_a;
            v_busy[k] = busy_a; v_c20[k] = ce2_a[0]; v_c21[k] = ce2_a[1];
            if (k == 4) r4 = rdata_a;
            rst_a = (k != rst_at);
        end
        req_a = 0;
        rst_a = 1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_ce", 32'(ce_a), 32'h3);
        chk("reset_ce2", 32'(ce2_a), 32'h0);
        chk("reset_strobes", 32'({re_a, we_a, oe_a, ack_a, busy_a}), 32'b11000);
        chk("reset_rdata", 32'(rdata_a), 32'h0);
        rst_a = 1; rst_b = 1;
        dq_a = 8'h3C;

        txn_a(1'b0, 3'd0, 17'h1234, 8'hA5, 8, 0, -1);
        chk("wr_ce0", 32'(v_ce0[7:0]), 32'hE1);
        chk("wr_we", 32'(v_we[7:0]), 32'hF3);
        chk("wr_dq_oe", 32'(v_oe[7:0]), 32'h1C);
        chk("wr_ack", 32'(v_ack[7:0]), 32'h20);
        chk("wr_busy", 32'(v_busy[7:0]), 32'h3E);
        chk("wr_ce2_0", 32'(v_c20[7:0]), 32'h1E);
        chk("wr_ce2_1", 32'(v_c21[7:0]), 32'h00);
        chk("wr_dq", 32'(sdq_a), 32'hA5);
        chk("wr_addr", 32'(saddr_a), 32'h1234);

        txn_a(1'b1, 3'd1, 17'h00FF, 8'h00, 8, 0, -1);
        chk("rd_re", 32'(v_re[7:0]), 32'hF3);
        chk("rd_we", 32'(v_we[7:0]), 32'hFF);
        chk("rd_ce1", 32'(v_ce1[7:0]), 32'hE1);
        chk("rd_ce0", 32'(v_ce0[7:0]), 32'hFF);
        chk("rd_data_c4", 32'(r4), 32'h3C);
        chk("rd_ack", 32'(v_ack[7:0]), 32'h20);

        dq_a = 8'h77;
        txn_a(1'b1, 3'd3, 17'h0010, 8'h00, 8, 0, -1);
        chk("oob_ce", 32'(v_ceall[7:0]), 32'hFF);
        chk("oob_ack", 32'(v_ack[7:0]), 32'h20);
        chk("oob_err", 32'(v_err[7:0]), 32'h20);
        chk("oob_rdata_kept", 32'(rdata_a), 32'h3C);

        txn_a(1'b0, 3'd0, 17'h0042, 8'h5A, 11, 0, 2);
        chk("rst_we_c2", 32'(v_we[2]), 32'h0);
        chk("rst_we_c3", 32'(v_we[3]), 32'h1);
        chk("rst_ce_c3", 32'(v_ceall[3]), 32'h1);
        chk("rst_oe_c3", 32'(v_oe[3]), 32'h0);
        chk("rst_no_ack", 32'(v_ack[10:0]), 32'h0);

        txn_a(1'b0, 3'd1, 17'h0100, 8'h11, 14, 1, -1);
        chk("b2b_busy", 32'(v_busy[13:0]), 32'h2FBE);
        chk("b2b_ack", 32'(v_ack[13:0]), 32'h0820);

        {v_we, v_ack} = '0;
        @(negedge clk);
        req_b = 1; rw_b = 0; bank_b = 3'd2; addr_b = 17'h00AA; wdata_b = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k > 0) req_b = 0;
            v_we[k] = we_b; v_ack[k] = ack_b;
        end
        chk("fast_we", 32'(v_we[4:0]), 32'b11101);
        chk("fast_ack", 32'(v_ack[4:0]), 32'b00100);

        fork
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                req_a = $urandom_range(0, 1) == 1; rw_a = $urandom_range(0, 1) == 1;
                bank_a = 3'($urandom_range(0, 3)); addr_a = 17'($urandom);
                wdata_a = 8'($urandom); dq_a = 8'($urandom);
                rst_a = $urandom_range(0, 99) != 0;
            end
            for (int j = 0; j < 1500; j++) begin
                @(negedge clk);
                req_b = $urandom_range(0, 1) == 1; rw_b = $urandom_range(0, 1) == 1;
                bank_b = 3'($urandom_range(0, 7)); addr_b = 17'($urandom);
                wdata_b = 8'($urandom); dq_b = 8'($urandom);
                rst_b = $urandom_range(0, 99) != 0;
            end
        join
        rst_a = 1; rst_b = 1; req_a = 0; req_b = 0;
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_access_sequencer.md
# sram_access_sequencer

Parametrised, clocked successor to the combinational SRAM strobe decoder. It accepts single read/write requests from the 6809 bus side and sequences CE, OE and WE to one of several SRAM banks with programmable setup, access and hold cycle counts. It captures read data and drives a write-data output enable, and reports completion with a one-cycle acknowledge. It sits between the address decoder and the external SRAM pins.

## Interface
- ADDR_WIDTH, 17: SRAM address bits.
- DATA_WIDTH, 8: data bus width.
- NUM_BANKS, 2: number of SRAM chips/banks, each with its own chip enable; 1..8.
- SETUP_CYCLES, 1: cycles of CE and address valid before the strobe; 0 allowed (state skipped).
- ACCESS_CYCLES, 2: cycles OE or WE is held active; minimum 1.
- HOLD_CYCLES, 1: cycles after strobe release with CE, address and write data held; 0 allowed.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  synchronous reset, active-low.
- i_req  in  1  request; sampled only in IDLE.
- i_RW  in  1  1 = read, 0 = write (6809 sense).
- i_bank  in  3  target bank index.
- i_addr  in  ADDR_WIDTH  request address.
- i_wdata  in  DATA_WIDTH  write data.
- o_busy  out  1  high whenever state is not IDLE.
- o_ack  out  1  one-cycle completion pulse.
- o_err  out  1  pulses with o_ack when i_bank >= NUM_BANKS.
- o_rdata  out  DATA_WIDTH  captured read data; holds until the next read completes.
- o_sram_addr  out  ADDR_WIDTH  latched address.
- o_sram_dq  out  DATA_WIDTH  latched write data.
- o_sram_dq_oe  out  1  drive o_sram_dq onto the pins.
- i_sram_dq  in  DATA_WIDTH  pin data in.
- o_CE  out  NUM_BANKS  per-bank chip enable, active low.
- o_CE2  out  NUM_BANKS  per-bank chip enable, active high.
- o_RE  out  1  output enable, active low.
- o_WE  out  1  write enable, active low.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE.
- IDLE with i_req=1: latch i_RW, i_bank, i_addr and i_wdata. Next state is SETUP if SETUP_CYCLES>0, otherwise ACCESS.
- SETUP: selected bank CE asserted (o_CE bit 0, o_CE2 bit 1). o_RE and o_WE stay inactive. Runs SETUP_CYCLES cycles.
- ACCESS: read drives o_RE=0; write drives o_WE=0 and o_sram_dq_oe=1. Runs ACCESS_CYCLES cycles.
- Read capture: i_sram_dq is registered into o_rdata on the clock edge that leaves ACCESS.
- HOLD: strobes inactive. CE and address stay held. o_sram_dq_oe stays 1 for writes. Runs HOLD_CYCLES cycles, then DONE. If HOLD_CYCLES=0, ACCESS goes directly to DONE.
- DONE: all CE inactive, o_sram_dq_oe=0, o_ack=1 for exactly one cycle. Next state is IDLE.
- i_req is ignored outside IDLE; the bus must wait on o_busy. A request held high through DONE is accepted in the following IDLE cycle as a new access.
- Out-of-range bank: the sequence runs normally with no CE asserted and no capture, so o_rdata is unchanged. o_err pulses with o_ack.
- A single down-counter, sized for the largest of the three cycle parameters, times SETUP, ACCESS and HOLD. It reloads on each state entry.

## Timing
- All SRAM-side outputs are registered (decoded from next-state), so they are glitch-free.
- Reset values: state IDLE, o_CE all 1, o_CE2 all 0, o_RE=1, o_WE=1, o_sram_dq_oe=0, o_ack=0, o_err=0, o_busy=0, o_rdata=0, o_sram_addr=0, o_sram_dq=0.
- Reset asserted mid-access: on that edge all strobes return to their reset values, no o_ack is issued, and the latched request is discarded.
- Latency from the accepting edge to the o_ack cycle is SETUP_CYCLES + ACCESS_CYCLES + HOLD_CYCLES + 1 cycles. With defaults, o_ack rises 5 cycles after acceptance.
- WE never overlaps a CE transition: CE leads WE by SETUP_CYCLES and trails it by HOLD_CYCLES.
- Back-to-back throughput is one access per (latency + 1) cycles, because IDLE is always visited between accesses.

## Test plan
- Default-parameter write: i_bank=0, i_addr=0x1234, i_wdata=0xA5. Expect:
  - o_CE[0]=0 in cycles 1–4; o_WE=0 only in cycles 2–3.
  - o_sram_dq_oe=1 in cycles 2–4, with o_sram_dq=0xA5 throughout.
  - o_ack in cycle 5; o_CE2[1]=0 throughout.
- Read from bank 1 at 0x00FF, SRAM model returning 0x3C: o_RE=0 in cycles 2–3, o_rdata=0x3C from cycle 4, o_ack in cycle 5, o_WE stays 1.
- SETUP_CYCLES=0, HOLD_CYCLES=0, ACCESS_CYCLES=1: write asserts o_WE in cycle 1 and o_ack in cycle 2.
- i_bank=3 with NUM_BANKS=2: no CE asserted, and o_err and o_ack pulse together in cycle 5.
- i_reset_n driven low in cycle 2 of a write: o_WE=1, all o_CE=1 and o_sram_dq_oe=0 after that edge, and o_ack never pulses.
- i_req held high continuously: accesses start at cycles 0, 6 and 12; o_busy is low exactly one cycle between accesses; i_req toggles mid-access have no effect.
